// File: rtl/fft_adder_arbiter.sv
// Round-robin arbiter sharing one single-cycle FP16 adder among N_REQ FFT requesters.
// Optional macro FFT_ADDER_ARB_OVF_STICKY_EN adds per-requester sticky overflow status.
module fft_adder_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    add_valid,
  output logic [DATA_W-1:0]       add_a,
  output logic [DATA_W-1:0]       add_b,
  input  logic [DATA_W-1:0]       add_res,
  input  logic                    add_ovf,
  input  logic                    add_res_vld,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_ovf,
  output logic [15:0]             issue_cnt,
`ifdef FFT_ADDER_ARB_OVF_STICKY_EN
  input  logic [N_REQ-1:0]        ovf_clr,
  output logic [N_REQ-1:0]        ovf_status,
`endif
  output logic                    proto_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 16;

  logic [IDX_W-1:0]  last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0]  tag_q, tag_d;
  logic              tag_vld_q, tag_vld_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_ovf_q, resp_ovf_d;
  logic              proto_err_q, proto_err_d;
  logic [IDX_W-1:0]  gnt_idx_c;
  logic [IDX_W-1:0]  cand_c;
  logic              gnt_any_c;
  logic              ret_c;

  // Rotating-priority search starting just after the last winner.
  always_comb begin
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    cand_c    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = IDX_W'((32'(last_gnt_q) + k) % N_REQ);
      if (!gnt_any_c && req_valid[cand_c]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = cand_c;
      end
    end
    if (rst) begin
      gnt_any_c = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (gnt_any_c) begin
      req_ready = N_REQ'(1) << gnt_idx_c;
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_any_c && (gnt_idx_c == IDX_W'(i))) begin
        add_a = req_a[i*DATA_W +: DATA_W];
        add_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign add_valid = gnt_any_c;

  // A result is only attributable when the tag from the previous cycle is live.
  always_comb begin
    ret_c        = add_res_vld & tag_vld_q;
    last_gnt_d   = gnt_any_c ? gnt_idx_c : last_gnt_q;
    tag_vld_d    = gnt_any_c;
    tag_d        = gnt_any_c ? gnt_idx_c : tag_q;
    issue_cnt_d  = issue_cnt_q + CNT_W'(gnt_any_c);
    resp_valid_d = ret_c ? (N_REQ'(1) << tag_q) : '0;
    resp_data_d  = ret_c ? add_res : resp_data_q;
    resp_ovf_d   = ret_c ? add_ovf : resp_ovf_q;
    proto_err_d  = proto_err_q | (add_res_vld & ~tag_vld_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q   <= IDX_W'(N_REQ - 1);
      tag_q        <= '0;
      tag_vld_q    <= 1'b0;
      issue_cnt_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_ovf_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      tag_q        <= tag_d;
      tag_vld_q    <= tag_vld_d;
      issue_cnt_q  <= issue_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_ovf_q   <= resp_ovf_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_ovf   = resp_ovf_q;
  assign issue_cnt  = issue_cnt_q;
  assign proto_err  = proto_err_q;

`ifdef FFT_ADDER_ARB_OVF_STICKY_EN
  logic [N_REQ-1:0] ovf_status_q, ovf_status_d;

  // Set tracks the response being registered this edge; set beats clear.
  always_comb begin
    ovf_status_d = (ovf_status_q & ~ovf_clr) | (resp_valid_d & {N_REQ{resp_ovf_d}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_status_q <= '0;
    end else begin
      ovf_status_q <= ovf_status_d;
    end
  end

  assign ovf_status = ovf_status_q;
`endif

endmodule

// File: tb/tb_fft_adder_arbiter.sv
// Bench for fft_adder_arbiter: behavioural FP16 adder model plus response scoreboard.
// Also exercises FFT_ADDER_ARB_OVF_STICKY_EN ports when that macro is defined.
`timescale 1ns/1ps
module tb_fft_adder_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           add_valid;
  logic [W-1:0]   add_a, add_b;
  logic [W-1:0]   add_res;
  logic           add_ovf;
  logic           add_res_vld;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           resp_ovf;
  logic [15:0]    issue_cnt;
  logic           proto_err;
`ifdef FFT_ADDER_ARB_OVF_STICKY_EN
  logic [N-1:0]   ovf_clr;
  logic [N-1:0]   ovf_status;
`endif

  fft_adder_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_res(add_res), .add_ovf(add_ovf), .add_res_vld(add_res_vld),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ovf(resp_ovf),
    .issue_cnt(issue_cnt),
`ifdef FFT_ADDER_ARB_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf_status(ovf_status),
`endif
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Positive-normal FP16 add with truncation; returns {overflow, result}.
  function automatic logic [16:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [4:0]  d;
    logic [11:0] mx, my, s;
    logic [5:0]  e;
    if (a[14:10] >= b[14:10]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = x[14:10] - y[14:10];
    mx = {2'b01, x[9:0]};
    my = {2'b01, y[9:0]};
    my = (d > 5'd11) ? 12'd0 : (my >> d);
    s  = mx + my;
    e  = {1'b0, x[14:10]};
    if (s[11]) begin s = s >> 1; e = e + 6'd1; end
    if (e >= 6'd31) return {1'b1, 16'h7C00};
    return {1'b0, 1'b0, e[4:0], s[9:0]};
  endfunction

  // Single-cycle adder model, reset with the arbiter; inj_vld forces a stray valid.
  logic adder_vld_q;
  logic inj_vld;
  always @(posedge clk) begin
    logic [16:0] r;
    r = fp_add(add_a, add_b);
    if (rst) adder_vld_q <= 1'b0;
    else     adder_vld_q <= add_valid;
    add_res <= r[15:0];
    add_ovf <= r[16];
  end
  assign add_res_vld = adder_vld_q | inj_vld;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [15:0] data;
    logic        ovf;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [1:0]  model_last;
  logic [15:0] exp_issue;

  // Response monitor: pops the scoreboard whenever a response is due or appears.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (resp_valid !== 4'b0) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL resp_unexpected cyc=%0d got valid=%b data=%h, expected no response", cyc, resp_valid, resp_data);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.due != cyc || resp_valid !== mon_e.tag || resp_data !== mon_e.data || resp_ovf !== mon_e.ovf)
          $display("FAIL resp_match cyc=%0d got valid=%b data=%h ovf=%b, expected cyc=%0d valid=%b data=%h ovf=%b",
                   cyc, resp_valid, resp_data, resp_ovf, mon_e.due, mon_e.tag, mon_e.data, mon_e.ovf);
        else n_pass++;
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      n_checks++;
      mon_e = sb.pop_front();
      $display("FAIL resp_missing cyc=%0d got valid=0, expected valid=%b data=%h", cyc, mon_e.tag, mon_e.data);
    end
  end

  // Drive one cycle of requests and predict the grant from the bench's own pointer.
  task automatic drive(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                       output logic [3:0] exp_gnt);
    logic [1:0]  idx;
    logic [16:0] r;
    @(posedge clk); #2;
    req_valid = v; req_a = a; req_b = b;
    exp_gnt = 4'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = 2'(int'(model_last) + k);
      if (exp_gnt == 4'b0 && v[idx]) exp_gnt = 4'b1 << idx;
    end
    if (exp_gnt != 4'b0) begin
      for (int i = 0; i < 4; i++) if (exp_gnt[i]) model_last = 2'(i);
      r = fp_add(a[model_last*16 +: 16], b[model_last*16 +: 16]);
      sb.push_back('{due: cyc + 2, tag: exp_gnt, data: r[15:0], ovf: r[16]});
      exp_issue = exp_issue + 16'd1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic [3:0] g;
    for (int i = 0; i < n; i++) drive(4'b0, 64'b0, 64'b0, g);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; req_valid = '0; inj_vld = 1'b0;
    sb.delete();
    model_last = 2'd3;
    exp_issue = 16'd0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd_op();
    return {1'b0, 5'($urandom_range(1, 30)), 10'($urandom)};
  endfunction

  task automatic test_reset();
    @(posedge clk); #2;
    rst = 1'b1; req_valid = 4'b1111; req_a = '1; req_b = '1; inj_vld = 1'b0;
    sb.delete(); model_last = 2'd3; exp_issue = 16'd0;
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (req_ready !== 4'b0 || add_valid !== 1'b0)
      $display("FAIL reset_gate got ready=%b add_valid=%b, expected 0000/0", req_ready, add_valid);
    else n_pass++;
    req_valid = 4'b0;
    #1;
    n_checks++;
    if (resp_valid !== 4'b0 || resp_data !== 16'h0 || resp_ovf !== 1'b0 || issue_cnt !== 16'h0 ||
        proto_err !== 1'b0 || add_a !== 16'h0 || add_b !== 16'h0)
      $display("FAIL reset_values got rv=%b rd=%h ro=%b ic=%h pe=%b aa=%h ab=%h, expected all 0",
               resp_valid, resp_data, resp_ovf, issue_cnt, proto_err, add_a, add_b);
    else n_pass++;
`ifdef FFT_ADDER_ARB_OVF_STICKY_EN
    n_checks++;
    if (ovf_status !== 4'b0) $display("FAIL reset_ovf_status got %b, expected 0000", ovf_status);
    else n_pass++;
`endif
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] g;
    do_reset();
    drive(4'b0100, {16'h0, 16'h3C00, 32'h0}, {16'h0, 16'h3C00, 32'h0}, g);
    n_checks++;
    if (req_ready !== 4'b0100 || add_valid !== 1'b1 || add_a !== 16'h3C00)
      $display("FAIL single_grant got ready=%b av=%b aa=%h, expected 0100/1/3c00", req_ready, add_valid, add_a);
    else n_pass++;
    idle(2);
    n_checks++;
    if (resp_valid !== 4'b0100 || resp_data !== 16'h4000 || resp_ovf !== 1'b0 || issue_cnt !== 16'd1)
      $display("FAIL single_resp got rv=%b rd=%h ro=%b ic=%0d, expected 0100/4000/0/1",
               resp_valid, resp_data, resp_ovf, issue_cnt);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_fairness();
    logic [3:0]  g;
    logic [63:0] a, b;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      a = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
      b = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
      drive(4'b1111, a, b, g);
      n_checks++;
      if (req_ready !== (4'b0001 << (k % 4)))
        $display("FAIL fair_order k=%0d got ready=%b, expected %b", k, req_ready, 4'b0001 << (k % 4));
      else n_pass++;
    end
    idle(1);
    n_checks++;
    if (issue_cnt !== 16'd8) $display("FAIL fair_issue_cnt got %0d, expected 8", issue_cnt);
    else n_pass++;
    idle(3);
  endtask

  task automatic test_overflow();
    logic [3:0] g;
    do_reset();
`ifdef FFT_ADDER_ARB_OVF_STICKY_EN
    ovf_clr = 4'b0;
`endif
    drive(4'b0010, {32'h0, 16'h7BFF, 16'h0}, {32'h0, 16'h7BFF, 16'h0}, g);
    idle(2);
    n_checks++;
    if (resp_valid !== 4'b0010 || resp_data !== 16'h7C00 || resp_ovf !== 1'b1)
      $display("FAIL ovf_resp got rv=%b rd=%h ro=%b, expected 0010/7c00/1", resp_valid, resp_data, resp_ovf);
    else n_pass++;
`ifdef FFT_ADDER_ARB_OVF_STICKY_EN
    n_checks++;
    if (ovf_status !== 4'b0010) $display("FAIL ovf_status_set got %b, expected 0010", ovf_status);
    else n_pass++;
    idle(3);
    n_checks++;
    if (ovf_status !== 4'b0010) $display("FAIL ovf_status_hold got %b, expected 0010", ovf_status);
    else n_pass++;
    @(posedge clk); #2 ovf_clr = 4'b0010;
    @(posedge clk); #2 ovf_clr = 4'b0000;
    #1;
    n_checks++;
    if (ovf_status !== 4'b0000) $display("FAIL ovf_status_clr got %b, expected 0000", ovf_status);
    else n_pass++;
`endif
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  g, v;
    logic [63:0] a, b;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      v = (k < 20) ? 4'b1111 : 4'($urandom);
      a = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
      b = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
      drive(v, a, b, g);
      n_checks++;
      if (req_ready !== g || add_valid !== (g != 4'b0))
        $display("FAIL b2b_grant k=%0d v=%b got ready=%b av=%b, expected %b", k, v, req_ready, add_valid, g);
      else n_pass++;
    end
    idle(1);
    n_checks++;
    if (issue_cnt !== exp_issue) $display("FAIL b2b_issue_cnt got %0d, expected %0d", issue_cnt, exp_issue);
    else n_pass++;
    idle(3);
    n_checks++;
    if (sb.size() != 0) $display("FAIL b2b_drain got %0d pending, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_proto_err();
    do_reset();
    @(posedge clk); #2 inj_vld = 1'b1;
    @(posedge clk); #2 inj_vld = 1'b0;
    #1;
    n_checks++;
    if (proto_err !== 1'b1 || resp_valid !== 4'b0)
      $display("FAIL proto_set got pe=%b rv=%b, expected 1/0000", proto_err, resp_valid);
    else n_pass++;
    idle(4);
    n_checks++;
    if (proto_err !== 1'b1 || resp_valid !== 4'b0)
      $display("FAIL proto_sticky got pe=%b rv=%b, expected 1/0000", proto_err, resp_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic [3:0] g;
    do_reset();
    drive(4'b0001, {48'h0, 16'h3C00}, {48'h0, 16'h4000}, g);
    @(posedge clk); #2;
    rst = 1'b1; req_valid = 4'b1111; sb.delete();
    #1;
    n_checks++;
    if (req_ready !== 4'b0 || add_valid !== 1'b0)
      $display("FAIL midrst_gate got ready=%b av=%b, expected 0000/0", req_ready, add_valid);
    else n_pass++;
    @(posedge clk); #2;
    req_valid = 4'b0; model_last = 2'd3; exp_issue = 16'd0;
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      n_checks++;
      if (resp_valid !== 4'b0 || resp_data !== 16'h0 || resp_ovf !== 1'b0 || issue_cnt !== 16'h0 || proto_err !== 1'b0)
        $display("FAIL midrst_outputs i=%0d got rv=%b rd=%h ro=%b ic=%h pe=%b, expected all 0",
                 i, resp_valid, resp_data, resp_ovf, issue_cnt, proto_err);
      else n_pass++;
    end
    drive(4'b1111, {4{16'h3C00}}, {4{16'h3C00}}, g);
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL midrst_priority got ready=%b, expected 0001", req_ready);
    else n_pass++;
    idle(3);
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    do_reset();
    for (int i = 0; i < 65535; i++) drive(4'b0001, {48'h0, 16'h3C00}, {48'h0, 16'h3800}, g);
    idle(1);
    n_checks++;
    if (issue_cnt !== 16'hFFFF) $display("FAIL wrap_max got %h, expected ffff", issue_cnt);
    else n_pass++;
    drive(4'b0001, {48'h0, 16'h3C00}, {48'h0, 16'h3800}, g);
    idle(1);
    n_checks++;
    if (issue_cnt !== 16'h0000) $display("FAIL wrap_zero got %h, expected 0000", issue_cnt);
    else n_pass++;
    idle(3);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; inj_vld = 1'b0;
    model_last = 2'd3; exp_issue = 16'd0;
`ifdef FFT_ADDER_ARB_OVF_STICKY_EN
    ovf_clr = '0;
`endif
    test_reset();
    test_single();
    test_fairness();
    test_overflow();
    test_back_to_back();
    test_proto_err();
    test_reset_midflight();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
